reg_file_sb: RTL and testbench

Parametrised integer register file for the RISC-V core, with two read ports and two write ports. The ALU write port serves the writeback stage. The MEM write port serves cache refill data returning from a load miss. A per-register pending scoreboard tracks registers whose load data is still outstanding in the cache system, and flags read hazards so the pipeline can stall. Optional write-to-read bypass and a hardwired zero register are included.

---
 rtl/reg_file_sb.sv | 92 +++++++++
 tb/tb_reg_file_sb.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2R/2W integer register file with a load-miss pending scoreboard.
// The ALU port writes back results; the MEM port delivers refills, which only land on pending registers.
module reg_file_sb #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int DEPTH    = 32,
  parameter int MAX_PEND = 4,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int CW       = $clog2(MAX_PEND + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [AW-1:0] RA1,
  input  logic [AW-1:0] RA2,
  output logic [DW-1:0] RD1,
  output logic [DW-1:0] RD2,
  input  logic          WE_ALU,
  input  logic [AW-1:0] WA_ALU,
  input  logic [DW-1:0] WD_ALU,
  input  logic          WE_MEM,
  input  logic [AW-1:0] WA_MEM,
  input  logic [DW-1:0] WD_MEM,
  input  logic          PEND_SET,
  input  logic [AW-1:0] PEND_ADDR,
  output logic          HAZ1,
  output logic          HAZ2,
  output logic [CW-1:0] PEND_CNT,
  output logic          PEND_FULL,
  output logic          PEND_OVF
);
  logic [DW-1:0]    r_mem [DEPTH];
  logic [DEPTH-1:0] r_pend;
  logic [DEPTH-1:0] w_pend_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_ovf;
  logic             w_alu, w_mem, w_ps, w_full, w_set, w_drop;
  logic             w_a1, w_a2, w_m1, w_m2;

  function automatic logic f_ok(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && !(ZERO_REG != 0 && a == '0);
  endfunction

  // A refill to a non-pending register is stale and behaves as if never issued.
  assign w_alu  = WE_ALU && f_ok(WA_ALU);
  assign w_mem  = WE_MEM && f_ok(WA_MEM) && r_pend[WA_MEM];
  assign w_ps   = PEND_SET && f_ok(PEND_ADDR);
  assign w_full = r_cnt == CW'(MAX_PEND);
  assign w_set  = w_ps && !r_pend[PEND_ADDR] && !w_full;
  assign w_drop = w_ps && !r_pend[PEND_ADDR] && w_full;

  assign w_a1 = BYPASS != 0 && w_alu && WA_ALU == RA1;
  assign w_a2 = BYPASS != 0 && w_alu && WA_ALU == RA2;
  assign w_m1 = BYPASS != 0 && w_mem && WA_MEM == RA1;
  assign w_m2 = BYPASS != 0 && w_mem && WA_MEM == RA2;

  assign RD1  = !f_ok(RA1) ? '0 : w_a1 ? WD_ALU : w_m1 ? WD_MEM : r_mem[RA1];
  assign RD2  = !f_ok(RA2) ? '0 : w_a2 ? WD_ALU : w_m2 ? WD_MEM : r_mem[RA2];
  assign HAZ1 = f_ok(RA1) && r_pend[RA1] && !(w_a1 || w_m1);
  assign HAZ2 = f_ok(RA2) && r_pend[RA2] && !(w_a2 || w_m2);

  assign PEND_CNT  = r_cnt;
  assign PEND_FULL = w_full;
  assign PEND_OVF  = r_ovf;

  // A set to the same address as a clearing write keeps the bit high.
  always_comb begin
    w_pend_nxt = '0;
    w_cnt_nxt  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_pend_nxt[i] = (r_pend[i] && !((w_alu && int'(WA_ALU) == i) || (w_mem && int'(WA_MEM) == i))) ||
                      (w_ps && int'(PEND_ADDR) == i && (r_pend[i] || w_set));
      w_cnt_nxt     = w_cnt_nxt + CW'(w_pend_nxt[i]);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_pend <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_mem) r_mem[WA_MEM] <= WD_MEM;
      if (w_alu) r_mem[WA_ALU] <= WD_ALU;
      r_pend <= w_pend_nxt;
      r_cnt  <= w_cnt_nxt;
      r_ovf  <= r_ovf | w_drop;
    end
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed checks of reg_file_sb writes, bypass, scoreboard and reset.
module tb_reg_file_sb;
  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  RA1, RA2, WA_ALU, WA_MEM, PEND_ADDR;
  logic [31:0] RD1, RD2, WD_ALU, WD_MEM;
  logic        WE_ALU, WE_MEM, PEND_SET, HAZ1, HAZ2, PEND_FULL, PEND_OVF;
  logic [2:0]  PEND_CNT;
  int          n_chk = 0;
  int          n_fail = 0;

  reg_file_sb dut (
    .CLK(CLK), .RST(RST), .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2),
    .WE_ALU(WE_ALU), .WA_ALU(WA_ALU), .WD_ALU(WD_ALU),
    .WE_MEM(WE_MEM), .WA_MEM(WA_MEM), .WD_MEM(WD_MEM),
    .PEND_SET(PEND_SET), .PEND_ADDR(PEND_ADDR), .HAZ1(HAZ1), .HAZ2(HAZ2),
    .PEND_CNT(PEND_CNT), .PEND_FULL(PEND_FULL), .PEND_OVF(PEND_OVF)
  );

  always #5 CLK = ~CLK;

  task automatic idle;
    RA1 = '0; RA2 = '0;
    WE_ALU = 1'b0; WA_ALU = '0; WD_ALU = '0;
    WE_MEM = 1'b0; WA_MEM = '0; WD_MEM = '0;
    PEND_SET = 1'b0; PEND_ADDR = '0;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
    idle();
  endtask

  task automatic test_reset;
    RST = 1'b0;
    idle();
    RA1 = 5'd5;
    #2;
    n_chk++; if (PEND_CNT !== 3'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", PEND_CNT); end
    n_chk++; if (PEND_FULL !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", PEND_FULL); end
    n_chk++; if (PEND_OVF !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", PEND_OVF); end
    n_chk++; if (RD1 !== 32'h0) begin n_fail++; $display("FAIL reset_rd1 got %h exp 0", RD1); end
    n_chk++; if (HAZ1 !== 1'b0) begin n_fail++; $display("FAIL reset_haz1 got %b exp 0", HAZ1); end
    @(posedge CLK);
    #1;
    RST = 1'b1;
    idle();
  endtask

  task automatic test_write_read;
    WE_ALU = 1'b1; WA_ALU = 5'd5; WD_ALU = 32'hDEADBEEF; RA2 = 5'd5;
    #1;
    n_chk++; if (RD2 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_alu got %h exp deadbeef", RD2); end
    tick();
    RA1 = 5'd5;
    #1;
    n_chk++; if (RD1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_x5 got %h exp deadbeef", RD1); end
    WE_ALU = 1'b1; WA_ALU = 5'd0; WD_ALU = 32'h77; RA1 = 5'd0;
    #1;
    n_chk++; if (RD1 !== 32'h0) begin n_fail++; $display("FAIL x0_bypass got %h exp 0", RD1); end
    tick();
    RA1 = 5'd0;
    #1;
    n_chk++; if (RD1 !== 32'h0) begin n_fail++; $display("FAIL x0_read got %h exp 0", RD1); end
  endtask

  task automatic test_pend_mem;
    PEND_SET = 1'b1; PEND_ADDR = 5'd7;
    tick();
    RA1 = 5'd7;
    #1;
    n_chk++; if (HAZ1 !== 1'b1) begin n_fail++; $display("FAIL pend_haz got %b exp 1", HAZ1); end
    n_chk++; if (PEND_CNT !== 3'd1) begin n_fail++; $display("FAIL pend_cnt1 got %0d exp 1", PEND_CNT); end
    WE_MEM = 1'b1; WA_MEM = 5'd7; WD_MEM = 32'h1234;
    #1;
    n_chk++; if (HAZ1 !== 1'b0) begin n_fail++; $display("FAIL refill_haz got %b exp 0", HAZ1); end
    n_chk++; if (RD1 !== 32'h1234) begin n_fail++; $display("FAIL refill_bypass got %h exp 1234", RD1); end
    tick();
    RA1 = 5'd7;
    #1;
    n_chk++; if (PEND_CNT !== 3'd0) begin n_fail++; $display("FAIL refill_cnt got %0d exp 0", PEND_CNT); end
    n_chk++; if (RD1 !== 32'h1234) begin n_fail++; $display("FAIL refill_data got %h exp 1234", RD1); end
  endtask

  task automatic test_full;
    for (int a = 1; a <= 4; a++) begin
      PEND_SET = 1'b1; PEND_ADDR = 5'(a);
      tick();
    end
    #1;
    n_chk++; if (PEND_CNT !== 3'd4) begin n_fail++; $display("FAIL full_cnt got %0d exp 4", PEND_CNT); end
    n_chk++; if (PEND_FULL !== 1'b1) begin n_fail++; $display("FAIL full_flag got %b exp 1", PEND_FULL); end
    n_chk++; if (PEND_OVF !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b exp 0", PEND_OVF); end
    PEND_SET = 1'b1; PEND_ADDR = 5'd9;
    tick();
    RA2 = 5'd9;
    #1;
    n_chk++; if (PEND_OVF !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b exp 1", PEND_OVF); end
    n_chk++; if (HAZ2 !== 1'b0) begin n_fail++; $display("FAIL drop_haz9 got %b exp 0", HAZ2); end
    n_chk++; if (PEND_CNT !== 3'd4) begin n_fail++; $display("FAIL drop_cnt got %0d exp 4", PEND_CNT); end
    PEND_SET = 1'b1; PEND_ADDR = 5'd10; WE_ALU = 1'b1; WA_ALU = 5'd1; WD_ALU = 32'h101;
    tick();
    RA1 = 5'd1; RA2 = 5'd10;
    #1;
    n_chk++; if (PEND_CNT !== 3'd3) begin n_fail++; $display("FAIL clr_cnt got %0d exp 3", PEND_CNT); end
    n_chk++; if (PEND_FULL !== 1'b0) begin n_fail++; $display("FAIL clr_full got %b exp 0", PEND_FULL); end
    n_chk++; if (HAZ2 !== 1'b0) begin n_fail++; $display("FAIL drop_haz10 got %b exp 0", HAZ2); end
    n_chk++; if (PEND_OVF !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", PEND_OVF); end
    n_chk++; if (RD1 !== 32'h101) begin n_fail++; $display("FAIL clr_data got %h exp 101", RD1); end
    WE_ALU = 1'b1; WA_ALU = 5'd2; WD_ALU = 32'h202;
    WE_MEM = 1'b1; WA_MEM = 5'd3; WD_MEM = 32'h303;
    tick();
    #1;
    n_chk++; if (PEND_CNT !== 3'd1) begin n_fail++; $display("FAIL dual_clr_cnt got %0d exp 1", PEND_CNT); end
    WE_ALU = 1'b1; WA_ALU = 5'd4; WD_ALU = 32'h404;
    tick();
    #1;
    n_chk++; if (PEND_CNT !== 3'd0) begin n_fail++; $display("FAIL drain_cnt got %0d exp 0", PEND_CNT); end
  endtask

  task automatic test_waw;
    PEND_SET = 1'b1; PEND_ADDR = 5'd3;
    tick();
    WE_ALU = 1'b1; WA_ALU = 5'd3; WD_ALU = 32'h55;
    tick();
    RA1 = 5'd3;
    #1;
    n_chk++; if (PEND_CNT !== 3'd0) begin n_fail++; $display("FAIL waw_cnt got %0d exp 0", PEND_CNT); end
    n_chk++; if (HAZ1 !== 1'b0) begin n_fail++; $display("FAIL waw_haz got %b exp 0", HAZ1); end
    WE_MEM = 1'b1; WA_MEM = 5'd3; WD_MEM = 32'hAA;
    #1;
    n_chk++; if (RD1 !== 32'h55) begin n_fail++; $display("FAIL stale_nobypass got %h exp 55", RD1); end
    tick();
    RA1 = 5'd3;
    #1;
    n_chk++; if (RD1 !== 32'h55) begin n_fail++; $display("FAIL stale_drop got %h exp 55", RD1); end
    n_chk++; if (PEND_CNT !== 3'd0) begin n_fail++; $display("FAIL stale_cnt got %0d exp 0", PEND_CNT); end
  endtask

  task automatic test_back_to_back;
    PEND_SET = 1'b1; PEND_ADDR = 5'd6;
    tick();
    WE_ALU = 1'b1; WA_ALU = 5'd6; WD_ALU = 32'h11;
    WE_MEM = 1'b1; WA_MEM = 5'd6; WD_MEM = 32'h22;
    RA1 = 5'd6;
    #1;
    n_chk++; if (RD1 !== 32'h11) begin n_fail++; $display("FAIL both_bypass got %h exp 11", RD1); end
    n_chk++; if (HAZ1 !== 1'b0) begin n_fail++; $display("FAIL both_haz got %b exp 0", HAZ1); end
    tick();
    RA1 = 5'd6;
    #1;
    n_chk++; if (RD1 !== 32'h11) begin n_fail++; $display("FAIL both_data got %h exp 11", RD1); end
    n_chk++; if (PEND_CNT !== 3'd0) begin n_fail++; $display("FAIL both_cnt got %0d exp 0", PEND_CNT); end
    PEND_SET = 1'b1; PEND_ADDR = 5'd8;
    tick();
    PEND_SET = 1'b1; PEND_ADDR = 5'd8;
    WE_MEM = 1'b1; WA_MEM = 5'd8; WD_MEM = 32'h88;
    tick();
    RA1 = 5'd8;
    #1;
    n_chk++; if (PEND_CNT !== 3'd1) begin n_fail++; $display("FAIL setwin_cnt got %0d exp 1", PEND_CNT); end
    n_chk++; if (HAZ1 !== 1'b1) begin n_fail++; $display("FAIL setwin_haz got %b exp 1", HAZ1); end
    n_chk++; if (RD1 !== 32'h88) begin n_fail++; $display("FAIL setwin_data got %h exp 88", RD1); end
  endtask

  task automatic test_reset_mid;
    PEND_SET = 1'b1; PEND_ADDR = 5'd2;
    tick();
    PEND_SET = 1'b1; PEND_ADDR = 5'd4;
    tick();
    #1;
    n_chk++; if (PEND_CNT !== 3'd3) begin n_fail++; $display("FAIL pre_rst_cnt got %0d exp 3", PEND_CNT); end
    RA1 = 5'd5; RA2 = 5'd6;
    #1;
    RST = 1'b0;
    #1;
    n_chk++; if (PEND_CNT !== 3'd0) begin n_fail++; $display("FAIL rst_cnt got %0d exp 0", PEND_CNT); end
    n_chk++; if (PEND_OVF !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %b exp 0", PEND_OVF); end
    n_chk++; if (RD1 !== 32'h0) begin n_fail++; $display("FAIL rst_rd1 got %h exp 0", RD1); end
    n_chk++; if (RD2 !== 32'h0) begin n_fail++; $display("FAIL rst_rd2 got %h exp 0", RD2); end
    tick();
    RST = 1'b1;
    WE_MEM = 1'b1; WA_MEM = 5'd2; WD_MEM = 32'h99; RA1 = 5'd2;
    #1;
    n_chk++; if (RD1 !== 32'h0) begin n_fail++; $display("FAIL late_refill_bypass got %h exp 0", RD1); end
    tick();
    RA1 = 5'd2;
    #1;
    n_chk++; if (RD1 !== 32'h0) begin n_fail++; $display("FAIL late_refill_data got %h exp 0", RD1); end
    n_chk++; if (PEND_CNT !== 3'd0) begin n_fail++; $display("FAIL late_refill_cnt got %0d exp 0", PEND_CNT); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_pend_mem();
    test_full();
    test_waw();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
